uart_recv: RTL and testbench

UART receiver: the receive-side counterpart of the existing UART transmitter. It deserialises 8N1 frames from the uart_rxd pin into bytes. It runs directly on clk with no internal clock divider, so CLK_FREQ is the actual frequency of clk. Each byte received is presented with a one-cycle done strobe; bad stop bits are flagged, and the byte is dropped.

---
 rtl/uart_recv_if.sv | 22 ++
 rtl/uart_recv.sv | 117 +++++++++++
 tb/tb_uart_recv.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_recv_if.sv
// Receive-side bundle of the UART: the byte plus its status strobes.
// The receiver drives it through master; a consumer reads it through slave.
interface uart_recv_if;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       uart_busy;

    modport master (
        output uart_data,
        output uart_done,
        output frame_err,
        output uart_busy
    );

    modport slave (
        input uart_data,
        input uart_done,
        input frame_err,
        input uart_busy
    );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver clocked directly on clk. Frames are sampled mid-bit
// after a three-flop synchroniser; bad stop bits drop the byte.
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic         clk,
    input  logic         sys_rst_n,
    input  logic         uart_rxd,
    uart_recv_if.master  rx
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam logic [15:0] CNT_MAX  = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_HALF = 16'(HALF);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] clk_cnt, clk_cnt_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;
    logic        rxd_d0, rxd_d1, rxd_d2;
    logic        start_edge, sample, wrap;
    logic [3:0]  bit_idx;

    assign start_edge = rxd_d2 & ~rxd_d1;
    assign sample     = (clk_cnt == CNT_HALF);
    assign wrap       = (clk_cnt == CNT_MAX);

    // Sync flops reset high so an idle line never looks like a falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_d0    <= 1'b1;
            rxd_d1    <= 1'b1;
            rxd_d2    <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rxd_d0    <= uart_rxd;
            rxd_d1    <= rxd_d0;
            rxd_d2    <= rxd_d1;
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            data_q    <= data_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        data_nxt    = data_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        bit_idx     = bit_cnt - 4'd1;

        if (state != IDLE) begin
            clk_cnt_nxt = wrap ? 16'd0 : clk_cnt + 16'd1;
            if (wrap) bit_cnt_nxt = bit_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                if (start_edge) state_nxt = START;
            end
            START: begin
                if (sample) state_nxt = rxd_d1 ? IDLE : DATA;
            end
            DATA: begin
                if (sample && bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                    shift_nxt[bit_idx[2:0]] = rxd_d1;
                if (wrap && bit_cnt == 4'd8) state_nxt = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (sample) begin
                    state_nxt = IDLE;
                    if (rxd_d1) begin
                        data_nxt = shift_reg;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE) begin
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
        end
    end

    assign rx.uart_data = data_q;
    assign rx.uart_done = done_q;
    assign rx.frame_err = err_q;
    assign rx.uart_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// Directed and randomized frames against a byte-level model of the receiver:
// good stop bit delivers the byte, bad stop bit raises one error.
module tb_uart_recv;
    localparam int BIT = 16;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic uart_rxd = 1'b1;

    uart_recv_if rx_if ();

    uart_recv #(.CLK_FREQ(1600), .UART_BPS(100)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rx        (rx_if)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Event log of the receiver's outputs, sampled on the falling edge.
    int         done_t[$];
    logic [7:0] done_d[$];
    int         err_t[$];
    int         n_overlap = 0, n_wide = 0, n_busy_bad = 0, n_unstable = 0;
    logic       prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rx_if.uart_done) begin
            done_t.push_back(cycle);
            done_d.push_back(rx_if.uart_data);
            if (rx_if.uart_busy || !prev_busy) n_busy_bad++;
        end
        if (rx_if.frame_err) err_t.push_back(cycle);
        if (rx_if.uart_done && rx_if.frame_err) n_overlap++;
        if ((rx_if.uart_done && prev_done) || (rx_if.frame_err && prev_err)) n_wide++;
        if (sys_rst_n && prev_rst && rx_if.uart_data !== prev_data && !rx_if.uart_done)
            n_unstable++;
        prev_done = rx_if.uart_done;
        prev_err  = rx_if.frame_err;
        prev_busy = rx_if.uart_busy;
        prev_rst  = sys_rst_n;
        prev_data = rx_if.uart_data;
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_done = 0;
    int         exp_err = 0;
    logic [7:0] exp_data = 8'h00;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(logic v, int n);
        uart_rxd = v;
        tick(n);
    endtask

    // Sends one frame on the pin and updates the byte-level model.
    task automatic send_frame(logic [7:0] b, logic stop);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
        drive_bit(stop, BIT);
        uart_rxd = 1'b1;
        if (stop) begin
            exp_done++;
            exp_data = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_model(string tag);
        check({tag, "_done_cnt"}, done_t.size(), exp_done);
        check({tag, "_err_cnt"}, err_t.size(), exp_err);
        check({tag, "_data"}, rx_if.uart_data, exp_data);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int busy_cycles;
        logic [7:0] b;
        logic stop;
        int gap;
        logic [7:0] pat;

        // Reset state
        #1;
        check("rst_data", rx_if.uart_data, 8'h00);
        check("rst_done", rx_if.uart_done, 1'b0);
        check("rst_err", rx_if.frame_err, 1'b0);
        check("rst_busy", rx_if.uart_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        tick(20);
        check("idle_busy", rx_if.uart_busy, 1'b0);

        // 1: single good frame
        send_frame(8'h55, 1'b1);
        tick(4);
        check_model("t1");
        check("t1_busy_fall_at_done", n_busy_bad, 0);

        // 4: bad stop bit keeps the previous byte
        send_frame(8'hFF, 1'b0);
        tick(4);
        check_model("t4");
        check("t4_data_kept", rx_if.uart_data, 8'h55);

        // 2: back-to-back frames
        n = done_t.size();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(4);
        check_model("t2");
        check("t2_count", done_t.size(), n + 2);
        if (done_t.size() >= n + 2) begin
            check("t2_spacing", done_t[n+1] - done_t[n], 160);
            check("t2_first", done_d[n], 8'hA3);
            check("t2_second", done_d[n+1], 8'h0F);
        end

        // 3: short glitch is rejected as a false start
        busy_cycles = 0;
        uart_rxd = 1'b0;
        tick(3);
        uart_rxd = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rx_if.uart_busy) busy_cycles++;
        end
        @(posedge clk);
        #1;
        check("t3_busy_cycles", busy_cycles, 9);
        check("t3_busy_end", rx_if.uart_busy, 1'b0);
        check_model("t3");

        // 5: reset during data bit 4 discards the partial byte
        pat = 8'h3C;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(pat[i], BIT);
        drive_bit(pat[4], BIT / 2);
        check("t5_busy_before_rst", rx_if.uart_busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("t5_rst_data", rx_if.uart_data, 8'h00);
        check("t5_rst_done", rx_if.uart_done, 1'b0);
        check("t5_rst_err", rx_if.frame_err, 1'b0);
        check("t5_rst_busy", rx_if.uart_busy, 1'b0);
        exp_data = 8'h00;
        uart_rxd = 1'b1;
        tick(5);
        sys_rst_n = 1'b1;
        tick(2 * BIT);
        check_model("t5_after_rst");
        send_frame(8'h3C, 1'b1);
        tick(4);
        check_model("t5");

        // 6: break gives one error, then a normal frame
        uart_rxd = 1'b0;
        tick(30 * BIT);
        uart_rxd = 1'b1;
        exp_err++;
        check("t6_busy_in_break", rx_if.uart_busy, 1'b0);
        tick(2 * BIT);
        check_model("t6_break");
        send_frame(8'h81, 1'b1);
        tick(4);
        check_model("t6");

        // Randomized frames with random stop bits and idle gaps
        for (int k = 0; k < 20; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            gap = stop ? $urandom_range(0, 20) : $urandom_range(2, 20);
            tick(gap);
            check_model($sformatf("rnd%0d", k));
        end
        tick(2 * BIT);

        check("no_overlap", n_overlap, 0);
        check("single_cycle_pulses", n_wide, 0);
        check("busy_fall_at_done", n_busy_bad, 0);
        check("data_stable", n_unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
